// File: rtl/comparator.sv
// Registered magnitude comparator for the ALU status path.
// Compares operand IN against a loadable reference register and
// produces one-hot lt/gt/eq flags one cycle after an enabled compare.
// All three flags read zero after reset until the first enabled compare.
module comparator #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] REF_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IN,
  input  logic             en,
  input  logic             signed_mode,
  input  logic             ref_load,
  input  logic [WIDTH-1:0] ref_in,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  // Reference value currently in effect for compares.
  logic [WIDTH-1:0] ref_q;

  // Combinational compare results; they only become visible once registered.
  logic cmp_lt;
  logic cmp_gt;
  logic cmp_eq;

  // Flag registers that drive the outputs directly.
  logic lt_q;
  logic gt_q;
  logic eq_q;

  // Compare IN against the held reference; equality does not depend on the
  // sign interpretation, and gt is whatever is neither lt nor eq so the
  // result is one-hot by construction.
  always_comb begin
    cmp_lt = 1'b0;
    cmp_eq = (IN == ref_q);
    if (signed_mode) begin
      cmp_lt = ($signed(IN) < $signed(ref_q));
    end else begin
      cmp_lt = (IN < ref_q);
    end
    cmp_gt = !cmp_lt && !cmp_eq;
  end

  // Reference register: a load takes effect from the following edge, so a
  // compare on the same edge still sees the old value held in ref_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= REF_RESET;
    end else if (ref_load) begin
      ref_q <= ref_in;
    end
  end

  // Flag registers: cleared to the "no result" state on reset, updated only
  // on enabled edges, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      lt_q <= 1'b0;
      gt_q <= 1'b0;
      eq_q <= 1'b0;
    end else if (en) begin
      lt_q <= cmp_lt;
      gt_q <= cmp_gt;
      eq_q <= cmp_eq;
    end
  end

  assign lt = lt_q;
  assign gt = gt_q;
  assign eq = eq_q;

endmodule

// File: tb/tb_comparator.sv
// Testbench for the registered magnitude comparator: a directed vector
// table for the corner cases followed by randomized traffic checked
// against an integer-arithmetic reference model.
module tb_comparator;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_val;
  logic             en;
  logic             signed_mode;
  logic             ref_load;
  logic [WIDTH-1:0] ref_in;
  logic             lt;
  logic             gt;
  logic             eq;

  int checks;
  int errors;

  typedef struct {
    logic             rst;
    logic             en;
    logic             sm;
    logic             ld;
    logic [WIDTH-1:0] in_v;
    logic [WIDTH-1:0] ref_v;
    logic             exp_lt;
    logic             exp_gt;
    logic             exp_eq;
    string            name;
  } vec_t;

  vec_t vecs[$];

  comparator #(.WIDTH(WIDTH), .REF_RESET(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .IN          (in_val),
    .en          (en),
    .signed_mode (signed_mode),
    .ref_load    (ref_load),
    .ref_in      (ref_in),
    .lt          (lt),
    .gt          (gt),
    .eq          (eq)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records one directed vector: inputs for one edge and the flags expected after it.
  function automatic void addVec(input logic r, input logic e, input logic s, input logic l,
                                 input logic [WIDTH-1:0] iv, input logic [WIDTH-1:0] rv,
                                 input logic [2:0] exp_lge, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.sm = s; v.ld = l;
    v.in_v = iv; v.ref_v = rv;
    v.exp_lt = exp_lge[2]; v.exp_gt = exp_lge[1]; v.exp_eq = exp_lge[0];
    v.name = nm;
    vecs.push_back(v);
  endfunction

  // Interprets a word as a plain number under the given mode.
  function automatic int toValue(input logic [WIDTH-1:0] v, input bit s);
    int u;
    u = int'(v);
    if (s && v[WIDTH-1]) return u - (1 << WIDTH);
    return u;
  endfunction

  // Drives inputs away from the active edge, then waits past the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic s, input logic l,
                               input logic [WIDTH-1:0] iv, input logic [WIDTH-1:0] rv);
    @(negedge clk);
    rst = r; en = e; signed_mode = s; ref_load = l; in_val = iv; ref_in = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic el, input logic eg, input logic ee);
    checks++;
    if ({lt, gt, eq} !== {el, eg, ee}) begin
      errors++;
      $display("[TB] FAIL %s: got lt/gt/eq=%b%b%b expected %b%b%b", nm, lt, gt, eq, el, eg, ee);
    end
  endtask

  initial begin
    int ref_m;
    bit m_lt, m_gt, m_eq;
    logic r, e, s, l;
    logic [WIDTH-1:0] iv, rv;

    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; signed_mode = 1'b0; ref_load = 1'b0;
    in_val = '0; ref_in = '0;

    //      rst en sm ld  IN        ref_in    lt/gt/eq
    addVec(1, 0, 0, 0, 16'h0000, 16'h0000, 3'b000, "reset");
    addVec(0, 0, 1, 0, 16'h0000, 16'h0000, 3'b000, "idle_no_result");
    addVec(0, 1, 1, 0, 16'h0000, 16'h0000, 3'b001, "first_eq");
    addVec(0, 1, 1, 0, 16'hFFFF, 16'h0000, 3'b100, "s_ffff_lt");
    addVec(0, 1, 0, 0, 16'hFFFF, 16'h0000, 3'b010, "u_ffff_gt");
    addVec(0, 1, 1, 0, 16'h8000, 16'h0000, 3'b100, "s_8000_lt");
    addVec(0, 1, 1, 0, 16'h7FFF, 16'h0000, 3'b010, "s_7fff_gt");
    addVec(0, 1, 0, 0, 16'h8000, 16'h0000, 3'b010, "u_8000_gt");
    addVec(0, 1, 0, 0, 16'h7FFF, 16'h0000, 3'b010, "u_7fff_gt");
    addVec(0, 1, 0, 1, 16'h0100, 16'h0100, 3'b010, "load_uses_old_ref");
    addVec(0, 1, 0, 0, 16'h0100, 16'h0000, 3'b001, "new_ref_eq");
    addVec(0, 1, 0, 0, 16'h0200, 16'h0000, 3'b010, "new_ref_gt");
    addVec(0, 0, 0, 0, 16'h0000, 16'h0000, 3'b010, "hold_1");
    addVec(0, 0, 1, 0, 16'h0000, 16'h0000, 3'b010, "hold_2");
    addVec(0, 0, 0, 0, 16'h0000, 16'h0000, 3'b010, "hold_3");
    addVec(1, 1, 0, 1, 16'h0005, 16'h1234, 3'b000, "reset_priority");
    addVec(0, 1, 1, 0, 16'h0000, 16'h0000, 3'b001, "ref_restored_eq");
    addVec(0, 0, 0, 1, 16'h0000, 16'h0001, 3'b001, "load_no_en_hold");
    addVec(0, 1, 1, 0, 16'h8000, 16'h0000, 3'b100, "s_8000_vs_1_lt");
    addVec(0, 1, 0, 0, 16'h8000, 16'h0000, 3'b010, "u_8000_vs_1_gt");
    addVec(0, 1, 1, 0, 16'h0001, 16'h0000, 3'b001, "s_1_vs_1_eq");
    addVec(0, 1, 1, 0, 16'h0000, 16'h0000, 3'b100, "s_0_vs_1_lt");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].sm, vecs[i].ld, vecs[i].in_v, vecs[i].ref_v);
      checkOutput(vecs[i].name, vecs[i].exp_lt, vecs[i].exp_gt, vecs[i].exp_eq);
    end

    // Multi-cycle sequence: load a signed negative reference, then compare
    // values straddling it, with a hold cycle in the middle.
    applyStimulus(0, 0, 1, 1, 16'h0000, 16'hFFF0);
    checkOutput("seq_load_hold", 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1, 1, 0, 16'hFFEF, 16'h0000);
    checkOutput("seq_s_below_neg_ref", 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1, 1, 0, 16'h0000, 16'h0000);
    checkOutput("seq_s_zero_vs_neg_ref", 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 1, 0, 0, 16'h0000, 16'h0000);
    checkOutput("seq_u_zero_vs_big_ref", 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 0, 16'hFFF0, 16'h0000);
    checkOutput("seq_eq_mode_indep", 1'b0, 1'b0, 1'b1);

    // Re-synchronise the model with a reset before random traffic.
    applyStimulus(1, 0, 0, 0, 16'h0000, 16'h0000);
    checkOutput("rand_start_reset", 1'b0, 1'b0, 1'b0);
    ref_m = 0;
    m_lt = 0; m_gt = 0; m_eq = 0;

    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 3) != 0);
      s = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 3) == 0);
      rv = 16'($urandom);
      case ($urandom_range(0, 6))
        0: iv = 16'(ref_m);
        1: iv = 16'(ref_m + 1);
        2: iv = 16'(ref_m - 1);
        3: iv = 16'h8000;
        4: iv = 16'h7FFF;
        5: iv = 16'hFFFF;
        default: iv = 16'($urandom);
      endcase

      // Reference model: integer compare against the reference held before this edge.
      if (r) begin
        m_lt = 0; m_gt = 0; m_eq = 0;
        ref_m = 0;
      end else begin
        if (e) begin
          m_lt = toValue(iv, s) < toValue(16'(ref_m), s);
          m_gt = toValue(iv, s) > toValue(16'(ref_m), s);
          m_eq = int'(iv) == ref_m;
        end
        if (l) ref_m = int'(rv);
      end

      applyStimulus(r, e, s, l, iv, rv);
      checkOutput($sformatf("rand_%0d", n), m_lt, m_gt, m_eq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator.md
Name: comparator

Overview:
- Registered magnitude comparator for the lab ALU datapath. Compares the 16-bit operand IN against a loadable reference value, which defaults to zero.
- Produces one-hot lt/gt/eq status flags.
- Sits after the ALU result bus and feeds status flags to branch/control logic.

Parameters:
- WIDTH, 16, bit width of IN and of the reference register.
- REF_RESET, 0, value the reference register takes on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- IN  input  WIDTH  operand to be compared.
- en  input  1  compare enable; flags update only when en=1.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned compare.
- ref_load  input  1  load ref_in into the reference register.
- ref_in  input  WIDTH  new reference value.
- lt  output  1  IN < reference (registered).
- gt  output  1  IN > reference (registered).
- eq  output  1  IN == reference (registered).

Behaviour:
- Reset (rst=1 at a rising edge of clk):
  - lt=0, gt=0, eq=0.
  - Reference register = REF_RESET.
  - rst has priority over en and ref_load.
- Compare:
  - At a rising edge with rst=0 and en=1, the flags register the result of comparing IN against the reference value held before that edge.
  - Latency is 1 cycle: the flags are valid the cycle after en was sampled.
- Hold: when en=0, the flags hold their previous values.
- One-hot: after the first enabled compare, exactly one of lt/gt/eq is 1. After reset and before any compare, all three flags are 0 ("no result").
- Signed mode (signed_mode=1): operands are interpreted as two's complement, so 16'h8000 is the most negative value and 16'h7FFF the most positive.
- Unsigned mode (signed_mode=0): plain magnitude compare, 16'h0000 to 16'hFFFF.
- signed_mode is sampled on the same edge as en.
- eq is independent of signed_mode.
- Reference load:
  - ref_load=1 at an edge (rst=0) writes ref_in into the reference register.
  - If en=1 on the same edge, the compare uses the old reference value; the new value takes effect from the next edge.
- Arithmetic: compare over the full WIDTH bits with no truncation. The signed compare must handle the sign-bit-differs cases correctly, e.g. 16'h8000 vs 16'h0001 gives lt=1 in signed mode and gt=1 in unsigned mode.
- Reset mid-operation: reset clears the flags and restores the reference regardless of any pending en/ref_load; no partial update occurs.
- Outputs must be driven directly from flops, with no combinational path from inputs to outputs.

Test Plan:
- Reset, then IN=0, en=1, signed_mode=1 for one cycle -> next cycle eq=1, lt=0, gt=0. Before that enabled edge, all flags are 0.
- Reference=0, signed_mode=1, IN=16'hFFFF -> lt=1. Same IN with signed_mode=0 -> gt=1.
- Signed_mode=1, IN=16'h8000 then 16'h7FFF -> lt=1, then gt=1. Repeat with signed_mode=0 -> gt=1, then gt=1.
- ref_load=1, ref_in=16'h0100 with en=1, IN=16'h0100 on the same edge -> gt=1 (old reference 0 used). Next cycle with en=1, IN=16'h0100 -> eq=1.
- After a compare that produced gt=1, set en=0 and change IN to 0 for 3 cycles -> gt stays 1, lt=0, eq=0.
- Assert rst with en=1 and ref_load=1 on the same edge -> all flags 0 and reference=REF_RESET. Next compare with IN=0 -> eq=1.
